rx_demod_sequencer: RTL and testbench
=====================================

RX_DEMOD_SEQUENCER -- requirements
Module: rx_demod_sequencer

Interface
REQ-001 SHALL have port s00_axi_aclk, input, 1: single clock for all state.
REQ-002 SHALL have port s00_axi_aresetn, input, 1: reset, asynchronous, active-low.
REQ-003 SHALL have port enable, input, 1: sequencer enable; 0 forces IDLE.
REQ-004 SHALL have port clr_cnt, input, 1: synchronous clear of all event counters.
REQ-005 SHALL have ports short_preamble_detected, long_preamble_detected, pkt_header_valid_strobe, pkt_header_valid, ht_unsupport, byte_out_strobe, fcs_out_strobe, fcs_ok, each input, 1: demod status from the dot11 core.
REQ-006 SHALL have port pkt_len, input, 16: PSDU length in bytes, sampled on the header strobe.
REQ-007 SHALL have ports sig_timeout_th and byte_timeout_th, input, 16: timeout thresholds in clock cycles; 0 disables that timeout.
REQ-008 SHALL have port rst_pulse_len, input, 4: receiver reset pulse length minus 1.
REQ-009 SHALL have port receiver_rst, output, 1: reset request to the dot11 core.
REQ-010 SHALL have port rx_busy, output, 1: high in any state other than IDLE.
REQ-011 SHALL have port state, output, 3: current state encoding.
REQ-012 SHALL have ports cnt_fcs_ok, cnt_fcs_err, cnt_sig_err, cnt_timeout and cnt_overrun, output, 16 each: event counters.

Function
REQ-013 SHALL implement states IDLE=0, WAIT_LTF=1, WAIT_SIG=2, PAYLOAD=3, RST=4.
REQ-014 SHALL clear a 16-bit state timer to 0 on every state entry and increment it once per cycle, saturating at 0xFFFF.
REQ-015 SHALL, in IDLE, move to WAIT_LTF on short_preamble_detected.
REQ-016 SHALL, in WAIT_LTF, move to WAIT_SIG on long_preamble_detected; otherwise, when sig_timeout_th != 0 and timer == sig_timeout_th, move to RST and increment cnt_timeout.
REQ-017 SHALL, in WAIT_SIG, on header strobe with pkt_header_valid=1 and ht_unsupport=0: capture pkt_len, clear the byte counter, and move to PAYLOAD.
REQ-018 SHALL, in WAIT_SIG, on header strobe with pkt_header_valid=0 or ht_unsupport=1: move to RST and increment cnt_sig_err.
REQ-019 SHALL, in WAIT_SIG with no header strobe, apply the sig_timeout_th timeout rule of REQ-016.
REQ-020 SHALL, in PAYLOAD, on each byte_out_strobe: increment the byte counter and clear the timer.
REQ-021 SHALL, in PAYLOAD, on fcs_out_strobe: move to IDLE and increment cnt_fcs_ok if fcs_ok=1, else cnt_fcs_err.
REQ-022 SHALL, in PAYLOAD, when the byte counter would exceed the captured pkt_len: move to RST and increment cnt_overrun.
REQ-023 SHALL, in PAYLOAD, when byte_timeout_th != 0 and timer == byte_timeout_th with no byte strobe: move to RST and increment cnt_timeout.
REQ-024 SHALL, in PAYLOAD, apply priority fcs_out_strobe > overrun > timeout when these occur in the same cycle.
REQ-025 SHALL remain in RST for rst_pulse_len+1 cycles, then move to IDLE.
REQ-026 SHALL drive receiver_rst as a registered output equal to (state==RST), so it rises at the same clock edge the state enters RST.
REQ-027 SHALL ignore all demod status inputs while in RST.
REQ-028 SHALL, when enable=0, go to IDLE at the next edge from any state, including RST, deassert receiver_rst, and hold counters and thresholds unchanged.
REQ-029 SHALL saturate counters at 0xFFFF.
REQ-030 SHALL let clr_cnt override any same-cycle increment, with counters reading 0 on the next cycle.
REQ-031 SHALL sample thresholds combinationally each cycle; a threshold change mid-state applies immediately.

Reset
REQ-032 SHALL, while s00_axi_aresetn=0, force state=IDLE, receiver_rst=0, rx_busy=0, timer=0, byte counter=0, captured length=0, and all counters=0, asynchronously.
REQ-033 SHALL take its first transition on the first rising edge after s00_axi_aresetn deasserts.

Verification
REQ-034 Scenario: STF, LTF, valid header with pkt_len=100, 100 byte strobes, fcs_out_strobe with fcs_ok=1 -> state returns to IDLE; cnt_fcs_ok=1; receiver_rst never asserted.
REQ-035 Scenario: sig_timeout_th=50, STF only -> RST entered after 51 cycles in WAIT_LTF; receiver_rst high for rst_pulse_len+1=4 cycles with rst_pulse_len=3; cnt_timeout=1.
REQ-036 Scenario: header strobe with ht_unsupport=1 -> RST; cnt_sig_err=1.
REQ-037 Scenario: pkt_len=10, 11 byte strobes -> RST on the 11th strobe; cnt_overrun=1; byte timeout and fcs_out_strobe in the same cycle -> cnt_fcs_ok increments, cnt_timeout does not.
REQ-038 Scenario: enable dropped mid-RST -> IDLE and receiver_rst=0 at the next edge; clr_cnt coincident with fcs_out_strobe -> all counters 0.
REQ-039 Scenario: s00_axi_aresetn asserted in PAYLOAD -> all outputs reach their reset values without a clock edge.

Source files
------------

// File: rtl/rx_demod_sequencer.sv
// ---------------------------------------------------------------------------
// rx_demod_sequencer
//
// Receive-side sequencer that follows the dot11 demodulator through a frame:
// short preamble -> long preamble -> SIGNAL header -> payload bytes -> FCS.
// It watches for timeouts, header errors and payload overruns. On any of
// these it holds the demodulator in reset for a programmable number of
// cycles, and it keeps saturating event counters.
//
// Ports
//   s00_axi_aclk, s00_axi_aresetn : clock, asynchronous active-low reset
//   enable                        : 0 parks the sequencer in IDLE
//   clr_cnt                       : synchronous clear of the event counters
//   short/long_preamble_detected,
//   pkt_header_valid_strobe,
//   pkt_header_valid, ht_unsupport,
//   byte_out_strobe,
//   fcs_out_strobe, fcs_ok        : demodulator status
//   pkt_len                       : PSDU length, captured on a good header
//   sig_timeout_th                : preamble/header timeout, 0 = disabled
//   byte_timeout_th               : inter-byte timeout, 0 = disabled
//   rst_pulse_len                 : receiver reset pulse length minus one
//   receiver_rst                  : reset request to the demodulator
//   rx_busy                       : sequencer is not in IDLE
//   state                         : current state encoding
//   cnt_*                         : saturating 16-bit event counters
// ---------------------------------------------------------------------------
module rx_demod_sequencer (
    input  logic        s00_axi_aclk,
    input  logic        s00_axi_aresetn,
    input  logic        enable,
    input  logic        clr_cnt,
    input  logic        short_preamble_detected,
    input  logic        long_preamble_detected,
    input  logic        pkt_header_valid_strobe,
    input  logic        pkt_header_valid,
    input  logic        ht_unsupport,
    input  logic        byte_out_strobe,
    input  logic        fcs_out_strobe,
    input  logic        fcs_ok,
    input  logic [15:0] pkt_len,
    input  logic [15:0] sig_timeout_th,
    input  logic [15:0] byte_timeout_th,
    input  logic [3:0]  rst_pulse_len,
    output logic        receiver_rst,
    output logic        rx_busy,
    output logic [2:0]  state,
    output logic [15:0] cnt_fcs_ok,
    output logic [15:0] cnt_fcs_err,
    output logic [15:0] cnt_sig_err,
    output logic [15:0] cnt_timeout,
    output logic [15:0] cnt_overrun
);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WAIT_LTF = 3'd1,
        ST_WAIT_SIG = 3'd2,
        ST_PAYLOAD  = 3'd3,
        ST_RST      = 3'd4
    } state_t;

    // Saturating increment shared by the timer and every event counter.
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        if (v == 16'hFFFF) begin
            return v;
        end else begin
            return v + 16'd1;
        end
    endfunction

    state_t      state_q, state_d;
    logic [15:0] timer_q, timer_d;
    logic [15:0] byte_cnt_q, byte_cnt_d;
    logic [15:0] len_q, len_d;
    logic        receiver_rst_q, rx_busy_q;

    logic [15:0] cnt_fcs_ok_q, cnt_fcs_ok_d;
    logic [15:0] cnt_fcs_err_q, cnt_fcs_err_d;
    logic [15:0] cnt_sig_err_q, cnt_sig_err_d;
    logic [15:0] cnt_timeout_q, cnt_timeout_d;
    logic [15:0] cnt_overrun_q, cnt_overrun_d;

    logic        timer_clr_s;
    logic        inc_fcs_ok_s, inc_fcs_err_s, inc_sig_err_s;
    logic        inc_timeout_s, inc_overrun_s;
    logic        sig_to_s, byte_to_s, overrun_s;
    logic [16:0] byte_inc_s;

    // Timeout and overrun qualifiers; thresholds are used live every cycle.
    always_comb begin
        sig_to_s   = (sig_timeout_th != 16'd0) && (timer_q == sig_timeout_th);
        byte_to_s  = (byte_timeout_th != 16'd0) && (timer_q == byte_timeout_th)
                     && !byte_out_strobe;
        // One bit wider so that a full 0xFFFF count cannot wrap into a false pass.
        byte_inc_s = {1'b0, byte_cnt_q} + 17'd1;
        overrun_s  = byte_out_strobe && (byte_inc_s > {1'b0, len_q});
    end

    // Next-state logic, length capture, byte counting and event flags.
    always_comb begin
        state_d       = state_q;
        len_d         = len_q;
        byte_cnt_d    = byte_cnt_q;
        timer_clr_s   = 1'b0;
        inc_fcs_ok_s  = 1'b0;
        inc_fcs_err_s = 1'b0;
        inc_sig_err_s = 1'b0;
        inc_timeout_s = 1'b0;
        inc_overrun_s = 1'b0;

        if (!enable) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (short_preamble_detected) begin
                        state_d = ST_WAIT_LTF;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_WAIT_LTF: begin
                    if (long_preamble_detected) begin
                        state_d = ST_WAIT_SIG;
                    end else if (sig_to_s) begin
                        state_d       = ST_RST;
                        inc_timeout_s = 1'b1;
                    end else begin
                        state_d = ST_WAIT_LTF;
                    end
                end
                ST_WAIT_SIG: begin
                    if (pkt_header_valid_strobe) begin
                        if (pkt_header_valid && !ht_unsupport) begin
                            len_d      = pkt_len;
                            byte_cnt_d = 16'd0;
                            state_d    = ST_PAYLOAD;
                        end else begin
                            state_d       = ST_RST;
                            inc_sig_err_s = 1'b1;
                        end
                    end else if (sig_to_s) begin
                        state_d       = ST_RST;
                        inc_timeout_s = 1'b1;
                    end else begin
                        state_d = ST_WAIT_SIG;
                    end
                end
                ST_PAYLOAD: begin
                    // FCS wins over overrun, overrun wins over timeout.
                    if (fcs_out_strobe) begin
                        state_d = ST_IDLE;
                        if (fcs_ok) begin
                            inc_fcs_ok_s = 1'b1;
                        end else begin
                            inc_fcs_err_s = 1'b1;
                        end
                    end else if (overrun_s) begin
                        state_d       = ST_RST;
                        inc_overrun_s = 1'b1;
                    end else if (byte_to_s) begin
                        state_d       = ST_RST;
                        inc_timeout_s = 1'b1;
                    end else if (byte_out_strobe) begin
                        byte_cnt_d  = byte_inc_s[15:0];
                        timer_clr_s = 1'b1;
                    end else begin
                        state_d = ST_PAYLOAD;
                    end
                end
                ST_RST: begin
                    // Demod status is ignored here; only the pulse length matters.
                    // >= keeps the exit reachable if rst_pulse_len shrinks mid-pulse.
                    if (timer_q >= {12'd0, rst_pulse_len}) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_RST;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State timer: restarts on every state change and on each payload byte.
    always_comb begin
        if ((state_d != state_q) || timer_clr_s) begin
            timer_d = 16'd0;
        end else begin
            timer_d = sat_inc(timer_q);
        end
    end

    // Event counters: clr_cnt takes precedence over any same-cycle event.
    always_comb begin
        cnt_fcs_ok_d  = cnt_fcs_ok_q;
        cnt_fcs_err_d = cnt_fcs_err_q;
        cnt_sig_err_d = cnt_sig_err_q;
        cnt_timeout_d = cnt_timeout_q;
        cnt_overrun_d = cnt_overrun_q;
        if (clr_cnt) begin
            cnt_fcs_ok_d  = 16'd0;
            cnt_fcs_err_d = 16'd0;
            cnt_sig_err_d = 16'd0;
            cnt_timeout_d = 16'd0;
            cnt_overrun_d = 16'd0;
        end else begin
            if (inc_fcs_ok_s) begin
                cnt_fcs_ok_d = sat_inc(cnt_fcs_ok_q);
            end else begin
                cnt_fcs_ok_d = cnt_fcs_ok_q;
            end
            if (inc_fcs_err_s) begin
                cnt_fcs_err_d = sat_inc(cnt_fcs_err_q);
            end else begin
                cnt_fcs_err_d = cnt_fcs_err_q;
            end
            if (inc_sig_err_s) begin
                cnt_sig_err_d = sat_inc(cnt_sig_err_q);
            end else begin
                cnt_sig_err_d = cnt_sig_err_q;
            end
            if (inc_timeout_s) begin
                cnt_timeout_d = sat_inc(cnt_timeout_q);
            end else begin
                cnt_timeout_d = cnt_timeout_q;
            end
            if (inc_overrun_s) begin
                cnt_overrun_d = sat_inc(cnt_overrun_q);
            end else begin
                cnt_overrun_d = cnt_overrun_q;
            end
        end
    end

    // State, datapath and counter registers, plus registered status outputs.
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            state_q        <= ST_IDLE;
            timer_q        <= 16'd0;
            byte_cnt_q     <= 16'd0;
            len_q          <= 16'd0;
            receiver_rst_q <= 1'b0;
            rx_busy_q      <= 1'b0;
            cnt_fcs_ok_q   <= 16'd0;
            cnt_fcs_err_q  <= 16'd0;
            cnt_sig_err_q  <= 16'd0;
            cnt_timeout_q  <= 16'd0;
            cnt_overrun_q  <= 16'd0;
        end else begin
            state_q        <= state_d;
            timer_q        <= timer_d;
            byte_cnt_q     <= byte_cnt_d;
            len_q          <= len_d;
            // Decoded from the next state so the flags track state_q exactly.
            receiver_rst_q <= (state_d == ST_RST);
            rx_busy_q      <= (state_d != ST_IDLE);
            cnt_fcs_ok_q   <= cnt_fcs_ok_d;
            cnt_fcs_err_q  <= cnt_fcs_err_d;
            cnt_sig_err_q  <= cnt_sig_err_d;
            cnt_timeout_q  <= cnt_timeout_d;
            cnt_overrun_q  <= cnt_overrun_d;
        end
    end

    assign state        = state_q;
    assign receiver_rst = receiver_rst_q;
    assign rx_busy      = rx_busy_q;
    assign cnt_fcs_ok   = cnt_fcs_ok_q;
    assign cnt_fcs_err  = cnt_fcs_err_q;
    assign cnt_sig_err  = cnt_sig_err_q;
    assign cnt_timeout  = cnt_timeout_q;
    assign cnt_overrun  = cnt_overrun_q;

endmodule

// File: tb/tb_rx_demod_sequencer.sv
// ---------------------------------------------------------------------------
// Testbench for rx_demod_sequencer. Expected values go into a scoreboard
// queue as stimulus is driven. They are popped and compared once the DUT has
// produced the corresponding outcome. Inputs change on the falling edge, and
// outputs are sampled there as well.
// ---------------------------------------------------------------------------
module tb_rx_demod_sequencer;

    localparam int O_STATE   = 0;
    localparam int O_RST     = 1;
    localparam int O_BUSY    = 2;
    localparam int O_FCS_OK  = 3;
    localparam int O_FCS_ERR = 4;
    localparam int O_SIG_ERR = 5;
    localparam int O_TIMEOUT = 6;
    localparam int O_OVERRUN = 7;

    typedef struct {
        int          sel;
        logic [15:0] val;
        string       tag;
    } sb_item_t;

    logic        clk = 1'b0;
    logic        aresetn = 1'b0;
    logic        enable = 1'b1;
    logic        clr_cnt = 1'b0;
    logic        short_pre = 1'b0;
    logic        long_pre = 1'b0;
    logic        hdr_strobe = 1'b0;
    logic        hdr_valid = 1'b0;
    logic        ht_unsup = 1'b0;
    logic        byte_strobe = 1'b0;
    logic        fcs_strobe = 1'b0;
    logic        fcs_ok = 1'b0;
    logic [15:0] pkt_len = 16'd0;
    logic [15:0] sig_th = 16'd0;
    logic [15:0] byte_th = 16'd0;
    logic [3:0]  rst_len = 4'd3;
    logic        receiver_rst, rx_busy;
    logic [2:0]  state;
    logic [15:0] cnt_fcs_ok, cnt_fcs_err, cnt_sig_err, cnt_timeout, cnt_overrun;

    int       tests_run = 0;
    int       tests_failed = 0;
    int       rst_cycles = 0;
    sb_item_t sb_q[$];

    rx_demod_sequencer dut (
        .s00_axi_aclk            (clk),
        .s00_axi_aresetn         (aresetn),
        .enable                  (enable),
        .clr_cnt                 (clr_cnt),
        .short_preamble_detected (short_pre),
        .long_preamble_detected  (long_pre),
        .pkt_header_valid_strobe (hdr_strobe),
        .pkt_header_valid        (hdr_valid),
        .ht_unsupport            (ht_unsup),
        .byte_out_strobe         (byte_strobe),
        .fcs_out_strobe          (fcs_strobe),
        .fcs_ok                  (fcs_ok),
        .pkt_len                 (pkt_len),
        .sig_timeout_th          (sig_th),
        .byte_timeout_th         (byte_th),
        .rst_pulse_len           (rst_len),
        .receiver_rst            (receiver_rst),
        .rx_busy                 (rx_busy),
        .state                   (state),
        .cnt_fcs_ok              (cnt_fcs_ok),
        .cnt_fcs_err             (cnt_fcs_err),
        .cnt_sig_err             (cnt_sig_err),
        .cnt_timeout             (cnt_timeout),
        .cnt_overrun             (cnt_overrun)
    );

    always #5 clk = ~clk;

    // Count every sampled cycle with receiver_rst high.
    always @(negedge clk) begin
        if (receiver_rst === 1'b1) rst_cycles = rst_cycles + 1;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run = tests_run + 1;
        if (obs !== exp) begin
            tests_failed = tests_failed + 1;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] observe(input int sel);
        case (sel)
            O_STATE:   return {29'd0, state};
            O_RST:     return {31'd0, receiver_rst};
            O_BUSY:    return {31'd0, rx_busy};
            O_FCS_OK:  return {16'd0, cnt_fcs_ok};
            O_FCS_ERR: return {16'd0, cnt_fcs_err};
            O_SIG_ERR: return {16'd0, cnt_sig_err};
            O_TIMEOUT: return {16'd0, cnt_timeout};
            O_OVERRUN: return {16'd0, cnt_overrun};
            default:   return 32'hDEAD_BEEF;
        endcase
    endfunction

    task automatic sb_push(input int sel, input logic [15:0] val, input string tag);
        sb_item_t it;
        it.sel = sel;
        it.val = val;
        it.tag = tag;
        sb_q.push_back(it);
    endtask

    task automatic sb_drain();
        sb_item_t it;
        while (sb_q.size() > 0) begin
            it = sb_q.pop_front();
            check_val(it.tag, observe(it.sel), {16'd0, it.val});
        end
    endtask

    task automatic push_counters(input logic [15:0] ok, input logic [15:0] err,
                                 input logic [15:0] sig, input logic [15:0] to,
                                 input logic [15:0] ovr, input string tag);
        sb_push(O_FCS_OK,  ok,  {tag, "_fcs_ok"});
        sb_push(O_FCS_ERR, err, {tag, "_fcs_err"});
        sb_push(O_SIG_ERR, sig, {tag, "_sig_err"});
        sb_push(O_TIMEOUT, to,  {tag, "_timeout"});
        sb_push(O_OVERRUN, ovr, {tag, "_overrun"});
    endtask

    task automatic wait_state(input logic [2:0] exp, input int budget, input string tag);
        int n = 0;
        while (state !== exp && n < budget) begin
            @(negedge clk);
            n = n + 1;
        end
        check_val(tag, {29'd0, state}, {29'd0, exp});
    endtask

    task automatic pulse_stf();
        short_pre = 1'b1; @(negedge clk); short_pre = 1'b0;
    endtask

    task automatic pulse_ltf();
        long_pre = 1'b1; @(negedge clk); long_pre = 1'b0;
    endtask

    task automatic pulse_hdr(input logic [15:0] len, input logic valid, input logic ht);
        pkt_len = len; hdr_valid = valid; ht_unsup = ht; hdr_strobe = 1'b1;
        @(negedge clk);
        hdr_strobe = 1'b0; hdr_valid = 1'b0; ht_unsup = 1'b0;
    endtask

    task automatic pulse_fcs(input logic ok);
        fcs_ok = ok; fcs_strobe = 1'b1; @(negedge clk); fcs_strobe = 1'b0; fcs_ok = 1'b0;
    endtask

    task automatic bytes(input int n);
        byte_strobe = 1'b1;
        repeat (n) @(negedge clk);
        byte_strobe = 1'b0;
    endtask

    task automatic enter_payload(input logic [15:0] len);
        pulse_stf();
        pulse_ltf();
        pulse_hdr(len, 1'b1, 1'b0);
    endtask

    initial begin
        int n;
        int snap;

        // Reset values while the reset is held.
        repeat (3) @(negedge clk);
        sb_push(O_STATE, 16'd0, "rst_state");
        sb_push(O_RST,   16'd0, "rst_receiver_rst");
        sb_push(O_BUSY,  16'd0, "rst_busy");
        push_counters(16'd0, 16'd0, 16'd0, 16'd0, 16'd0, "rst");
        sb_drain();
        aresetn = 1'b1;
        @(negedge clk);

        // Good frame of 100 bytes with a correct FCS.
        snap = rst_cycles;
        pulse_stf();
        check_val("stf_state", {29'd0, state}, 32'd1);
        check_val("stf_busy", {31'd0, rx_busy}, 32'd1);
        pulse_ltf();
        check_val("ltf_state", {29'd0, state}, 32'd2);
        pulse_hdr(16'd100, 1'b1, 1'b0);
        check_val("hdr_state", {29'd0, state}, 32'd3);
        bytes(100);
        check_val("bytes100_state", {29'd0, state}, 32'd3);
        pulse_fcs(1'b1);
        sb_push(O_STATE, 16'd0, "good_state");
        push_counters(16'd1, 16'd0, 16'd0, 16'd0, 16'd0, "good");
        sb_drain();
        check_val("good_no_rst", rst_cycles - snap, 32'd0);

        // Preamble timeout in WAIT_LTF with a 4-cycle receiver reset.
        sig_th = 16'd50;
        rst_len = 4'd3;
        pulse_stf();
        n = 0;
        while (state === 3'd1 && n < 200) begin
            n = n + 1;
            @(negedge clk);
        end
        check_val("ltf_cycles", n, 32'd51);
        check_val("to_state_rst", {29'd0, state}, 32'd4);
        n = 0;
        while (receiver_rst === 1'b1 && n < 40) begin
            n = n + 1;
            @(negedge clk);
        end
        check_val("rst_pulse_cycles", n, 32'd4);
        sig_th = 16'd0;
        sb_push(O_STATE, 16'd0, "to_back_idle");
        push_counters(16'd1, 16'd0, 16'd0, 16'd1, 16'd0, "sigto");
        sb_drain();

        // Unsupported HT header.
        pulse_stf();
        pulse_ltf();
        pulse_hdr(16'd20, 1'b1, 1'b1);
        check_val("ht_state_rst", {29'd0, state}, 32'd4);
        check_val("ht_receiver_rst", {31'd0, receiver_rst}, 32'd1);
        wait_state(3'd0, 20, "ht_wait_idle");
        push_counters(16'd1, 16'd0, 16'd1, 16'd1, 16'd0, "ht");
        sb_drain();

        // Overrun on the 11th byte of a 10-byte packet.
        enter_payload(16'd10);
        bytes(10);
        check_val("ovr_10_state", {29'd0, state}, 32'd3);
        bytes(1);
        check_val("ovr_11_state", {29'd0, state}, 32'd4);
        wait_state(3'd0, 20, "ovr_wait_idle");
        push_counters(16'd1, 16'd0, 16'd1, 16'd1, 16'd1, "ovr");
        sb_drain();

        // FCS and byte timeout in the same cycle: FCS wins.
        byte_th = 16'd5;
        enter_payload(16'd10);
        repeat (5) @(negedge clk);
        pulse_fcs(1'b1);
        sb_push(O_STATE, 16'd0, "fcs_vs_to_state");
        push_counters(16'd2, 16'd0, 16'd1, 16'd1, 16'd1, "fcs_vs_to");
        sb_drain();

        // Byte timeout alone.
        enter_payload(16'd10);
        bytes(2);
        repeat (5) @(negedge clk);
        check_val("bto_pre_state", {29'd0, state}, 32'd3);
        @(negedge clk);
        check_val("bto_state_rst", {29'd0, state}, 32'd4);
        byte_th = 16'd0;
        wait_state(3'd0, 20, "bto_wait_idle");
        push_counters(16'd2, 16'd0, 16'd1, 16'd2, 16'd1, "bto");
        sb_drain();

        // Enable dropped in the middle of a receiver reset.
        pulse_stf();
        pulse_ltf();
        pulse_hdr(16'd8, 1'b0, 1'b0);
        check_val("en_state_rst", {29'd0, state}, 32'd4);
        @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        sb_push(O_STATE, 16'd0, "en_drop_state");
        sb_push(O_RST,   16'd0, "en_drop_receiver_rst");
        sb_push(O_BUSY,  16'd0, "en_drop_busy");
        push_counters(16'd2, 16'd0, 16'd2, 16'd2, 16'd1, "en_drop");
        sb_drain();
        enable = 1'b1;

        // clr_cnt coincident with an FCS strobe.
        enter_payload(16'd10);
        clr_cnt = 1'b1;
        pulse_fcs(1'b1);
        clr_cnt = 1'b0;
        sb_push(O_STATE, 16'd0, "clr_state");
        push_counters(16'd0, 16'd0, 16'd0, 16'd0, 16'd0, "clr");
        sb_drain();

        // Bad FCS, then asynchronous reset asserted in PAYLOAD.
        enter_payload(16'd5);
        pulse_fcs(1'b0);
        sb_push(O_FCS_ERR, 16'd1, "bad_fcs_err");
        sb_drain();
        enter_payload(16'd20);
        bytes(3);
        check_val("arst_pre_state", {29'd0, state}, 32'd3);
        #2 aresetn = 1'b0;
        #1;
        sb_push(O_STATE, 16'd0, "arst_state");
        sb_push(O_RST,   16'd0, "arst_receiver_rst");
        sb_push(O_BUSY,  16'd0, "arst_busy");
        push_counters(16'd0, 16'd0, 16'd0, 16'd0, 16'd0, "arst");
        sb_drain();
        @(negedge clk);
        aresetn = 1'b1;
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
